// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - VGA timing defaults, totals helpers and control-state encoding
package vga_timing_pkg;

   localparam int DIV_DEF    = 4;
   localparam int H_VIS_DEF  = 640;
   localparam int H_FP_DEF   = 16;
   localparam int H_SYNC_DEF = 96;
   localparam int H_BP_DEF   = 48;
   localparam int V_VIS_DEF  = 480;
   localparam int V_FP_DEF   = 10;
   localparam int V_SYNC_DEF = 2;
   localparam int V_BP_DEF   = 33;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } ctrl_state_e;

   function automatic int h_tot(input int vis, input int fp, input int sync, input int bp);
      return vis + fp + sync + bp;
   endfunction

   function automatic int v_tot(input int vis, input int fp, input int sync, input int bp);
      return vis + fp + sync + bp;
   endfunction

endpackage

// File: rtl/pix_tick_gen.sv
// rtl/pix_tick_gen.sv - divides clk into a one-cycle pixel enable every DIV cycles
module pix_tick_gen #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic clr_n,
   input  logic run,
   output logic pix_tick
);

   localparam int            CW      = $clog2(DIV);
   localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = '0;
      if (run && cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign pix_tick = run && (cnt_q == CNT_MAX);

endmodule

// File: rtl/vga_sync_ctrl.sv
// rtl/vga_sync_ctrl.sv - VGA run/drain control, h/v counters, sync, display enable and markers
module vga_sync_ctrl
   import vga_timing_pkg::*;
#(
   parameter int DIV    = DIV_DEF,
   parameter int H_VIS  = H_VIS_DEF,
   parameter int H_FP   = H_FP_DEF,
   parameter int H_SYNC = H_SYNC_DEF,
   parameter int H_BP   = H_BP_DEF,
   parameter int V_VIS  = V_VIS_DEF,
   parameter int V_FP   = V_FP_DEF,
   parameter int V_SYNC = V_SYNC_DEF,
   parameter int V_BP   = V_BP_DEF
) (
   input  logic       clk,
   input  logic       clr_n,
   input  logic       en,
   output logic       pix_tick,
   output logic       hsync,
   output logic       vsync,
   output logic       de,
   output logic [9:0] hc,
   output logic [9:0] vc,
   output logic       line_start,
   output logic       frame_start,
   output logic       busy
);

   localparam int H_TOT = h_tot(H_VIS, H_FP, H_SYNC, H_BP);
   localparam int V_TOT = v_tot(V_VIS, V_FP, V_SYNC, V_BP);

   if (H_TOT > 1024) begin : g_h_tot_chk
      $error("H_TOT exceeds the 10-bit column counter");
   end
   if (V_TOT > 1024) begin : g_v_tot_chk
      $error("V_TOT exceeds the 10-bit line counter");
   end
   if (DIV < 2) begin : g_div_chk
      $error("DIV must be at least 2");
   end

   localparam logic [9:0] H_LAST  = 10'(H_TOT - 1);
   localparam logic [9:0] V_LAST  = 10'(V_TOT - 1);
   localparam logic [9:0] H_VIS_W = 10'(H_VIS);
   localparam logic [9:0] V_VIS_W = 10'(V_VIS);
   localparam logic [9:0] HS_BEG  = 10'(H_VIS + H_FP);
   localparam logic [9:0] HS_END  = 10'(H_VIS + H_FP + H_SYNC);
   localparam logic [9:0] VS_BEG  = 10'(V_VIS + V_FP);
   localparam logic [9:0] VS_END  = 10'(V_VIS + V_FP + V_SYNC);

   ctrl_state_e state_q, state_d;
   logic [9:0]  hc_q, hc_d, vc_q, vc_d;
   logic        hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d, busy_q, busy_d;
   logic        line_start_q, line_start_d, frame_start_q, frame_start_d;
   logic        running, live, first, wrap_h, wrap_f;

   pix_tick_gen #(.DIV(DIV)) u_pix_tick_gen (
      .clk      (clk),
      .clr_n    (clr_n),
      .run      (running),
      .pix_tick (pix_tick)
   );

   assign running = (state_q != IDLE);
   assign wrap_h  = pix_tick && (hc_q == H_LAST);
   assign wrap_f  = wrap_h && (vc_q == V_LAST);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (en) state_d = RUN;
         RUN:     if (!en) state_d = DRAIN;
         DRAIN: begin
            if (en)          state_d = RUN;
            else if (wrap_f) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      hc_d = hc_q;
      vc_d = vc_q;
      if (pix_tick) begin
         if (wrap_h) begin
            hc_d = '0;
            vc_d = (vc_q == V_LAST) ? '0 : vc_q + 10'd1;
         end else begin
            hc_d = hc_q + 10'd1;
         end
      end

      // Outputs are computed from next-cycle values so they line up with hc/vc;
      // the first IDLE cycle and the final DRAIN edge are both excluded by live.
      live          = running && (state_d != IDLE);
      first         = running && !busy_q;
      busy_d        = live;
      de_d          = live && (hc_d < H_VIS_W) && (vc_d < V_VIS_W);
      hsync_d       = !((hc_d >= HS_BEG) && (hc_d < HS_END));
      vsync_d       = !((vc_d >= VS_BEG) && (vc_d < VS_END));
      line_start_d  = live && (wrap_h || first);
      frame_start_d = live && (wrap_f || first);
   end

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         state_q       <= IDLE;
         hc_q          <= '0;
         vc_q          <= '0;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         de_q          <= 1'b0;
         busy_q        <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         hc_q          <= hc_d;
         vc_q          <= vc_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         de_q          <= de_d;
         busy_q        <= busy_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign hc          = hc_q;
   assign vc          = vc_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign de          = de_q;
   assign busy        = busy_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_ctrl.sv
// tb/tb_vga_sync_ctrl.sv - directed bench for vga_sync_ctrl on a reduced 15x8-pixel raster
module tb_vga_sync_ctrl;

   // Raster: H 8/2/3/2 (H_TOT 15, hsync hc 10..12), V 4/1/2/1 (V_TOT 8, vsync vc 5..6), DIV 4
   logic       clk = 1'b0;
   logic       clr_n, en;
   logic       pix_tick, hsync, vsync, de, line_start, frame_start, busy;
   logic [9:0] hc, vc;
   int         pass_cnt = 0;
   int         total_cnt = 0;

   vga_sync_ctrl #(
      .DIV(4), .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
   ) dut (
      .clk         (clk),
      .clr_n       (clr_n),
      .en          (en),
      .pix_tick    (pix_tick),
      .hsync       (hsync),
      .vsync       (vsync),
      .de          (de),
      .hc          (hc),
      .vc          (vc),
      .line_start  (line_start),
      .frame_start (frame_start),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_pos(input int h, input int v);
      bit found = 0;
      for (int i = 0; i < 2000 && !found; i++) begin
         if (hc == 10'(h) && vc == 10'(v)) found = 1;
         else step(1);
      end
      total_cnt++;
      if (!found) $display("FAIL wait_pos(%0d,%0d): timed out at hc=%0d vc=%0d", h, v, hc, vc);
      else pass_cnt++;
   endtask

   task automatic test_reset;
      clr_n = 1'b0;
      en    = 1'b1;
      step(3);
      total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b exp 0", busy); else pass_cnt++;
      total_cnt++; if (de !== 1'b0) $display("FAIL rst_de: got %b exp 0", de); else pass_cnt++;
      total_cnt++; if (hsync !== 1'b1 || vsync !== 1'b1) $display("FAIL rst_sync: got %b%b exp 11", hsync, vsync); else pass_cnt++;
      total_cnt++; if (hc !== 10'd0 || vc !== 10'd0) $display("FAIL rst_pos: got %0d,%0d exp 0,0", hc, vc); else pass_cnt++;
      total_cnt++; if (pix_tick !== 1'b0) $display("FAIL rst_tick: got %b exp 0", pix_tick); else pass_cnt++;
      total_cnt++; if (line_start !== 1'b0 || frame_start !== 1'b0) $display("FAIL rst_markers: got %b%b exp 00", line_start, frame_start); else pass_cnt++;
   endtask

   task automatic test_start;
      clr_n = 1'b1;
      step(1);
      total_cnt++; if (busy !== 1'b0 || frame_start !== 1'b0) $display("FAIL start_n0: busy/fs got %b%b exp 00", busy, frame_start); else pass_cnt++;
      step(1);
      total_cnt++; if (busy !== 1'b1) $display("FAIL start_busy: got %b exp 1", busy); else pass_cnt++;
      total_cnt++; if (de !== 1'b1) $display("FAIL start_de: got %b exp 1", de); else pass_cnt++;
      total_cnt++; if (frame_start !== 1'b1 || line_start !== 1'b1) $display("FAIL start_markers: got %b%b exp 11", frame_start, line_start); else pass_cnt++;
      total_cnt++; if (pix_tick !== 1'b0 || hc !== 10'd0) $display("FAIL start_n1: tick/hc got %b/%0d exp 0/0", pix_tick, hc); else pass_cnt++;
      step(1);
      total_cnt++; if (frame_start !== 1'b0 || pix_tick !== 1'b0) $display("FAIL start_n2: fs/tick got %b%b exp 00", frame_start, pix_tick); else pass_cnt++;
      step(1);
      total_cnt++; if (pix_tick !== 1'b1) $display("FAIL start_first_tick: got %b exp 1", pix_tick); else pass_cnt++;
      step(1);
      total_cnt++; if (hc !== 10'd1 || pix_tick !== 1'b0) $display("FAIL start_hc1: hc/tick got %0d/%b exp 1/0", hc, pix_tick); else pass_cnt++;
   endtask

   task automatic test_frame;
      int de_n = 0, hs_n = 0, vs_n = 0, ls_n = 0, fs_n = 0, pt_n = 0;
      int hs_fall_hc = -1, hs_rise_hc = -1, de_fall_hc = -1, vs_fall_vc = -1;
      logic prev_de = 1'b0, prev_hs = 1'b1;
      bit got_fs = 0;
      for (int i = 0; i < 1000 && !got_fs; i++) begin
         if (frame_start === 1'b1) got_fs = 1;
         else step(1);
      end
      total_cnt++; if (!got_fs) $display("FAIL frame_wait: no frame_start seen"); else pass_cnt++;
      for (int i = 0; i < 480; i++) begin
         if (de === 1'b1) de_n++;
         if (hsync === 1'b0) hs_n++;
         if (vsync === 1'b0) vs_n++;
         if (line_start === 1'b1) ls_n++;
         if (frame_start === 1'b1) fs_n++;
         if (pix_tick === 1'b1) pt_n++;
         if (hsync === 1'b0 && prev_hs === 1'b1 && hs_fall_hc < 0) hs_fall_hc = int'(hc);
         if (hsync === 1'b1 && prev_hs === 1'b0 && hs_rise_hc < 0) hs_rise_hc = int'(hc);
         if (de === 1'b0 && prev_de === 1'b1 && de_fall_hc < 0) de_fall_hc = int'(hc);
         if (vsync === 1'b0 && vs_fall_vc < 0) vs_fall_vc = int'(vc);
         prev_hs = hsync;
         prev_de = de;
         step(1);
      end
      total_cnt++; if (frame_start !== 1'b1) $display("FAIL frame_period: frame_start got %b after 480 clk exp 1", frame_start); else pass_cnt++;
      total_cnt++; if (fs_n != 1) $display("FAIL frame_fs_count: got %0d exp 1", fs_n); else pass_cnt++;
      total_cnt++; if (ls_n != 8) $display("FAIL frame_ls_count: got %0d exp 8", ls_n); else pass_cnt++;
      total_cnt++; if (pt_n != 120) $display("FAIL frame_ticks: got %0d exp 120", pt_n); else pass_cnt++;
      total_cnt++; if (de_n != 128) $display("FAIL frame_de_clk: got %0d exp 128", de_n); else pass_cnt++;
      total_cnt++; if (hs_n != 96) $display("FAIL frame_hsync_clk: got %0d exp 96", hs_n); else pass_cnt++;
      total_cnt++; if (vs_n != 120) $display("FAIL frame_vsync_clk: got %0d exp 120", vs_n); else pass_cnt++;
      total_cnt++; if (hs_fall_hc != 10) $display("FAIL hsync_fall_hc: got %0d exp 10", hs_fall_hc); else pass_cnt++;
      total_cnt++; if (hs_rise_hc != 13) $display("FAIL hsync_rise_hc: got %0d exp 13", hs_rise_hc); else pass_cnt++;
      total_cnt++; if (de_fall_hc != 8) $display("FAIL de_fall_hc: got %0d exp 8", de_fall_hc); else pass_cnt++;
      total_cnt++; if (vs_fall_vc != 5) $display("FAIL vsync_fall_vc: got %0d exp 5", vs_fall_vc); else pass_cnt++;
   endtask

   task automatic test_drain;
      int k = 0, fs_n = 0, hs_n = 0, pt_n = 0;
      int prev_h = 0, prev_v = 0;
      wait_pos(3, 2);
      en = 1'b0;
      while (busy === 1'b1 && k < 1000) begin
         prev_h = int'(hc);
         prev_v = int'(vc);
         step(1);
         k++;
         if (frame_start === 1'b1) fs_n++;
         if (hsync === 1'b0) hs_n++;
      end
      total_cnt++; if (k != 348) $display("FAIL drain_len: got %0d clk exp 348", k); else pass_cnt++;
      total_cnt++; if (prev_h != 14 || prev_v != 7) $display("FAIL drain_last_pos: got %0d,%0d exp 14,7", prev_h, prev_v); else pass_cnt++;
      total_cnt++; if (hs_n != 72) $display("FAIL drain_hsync_clk: got %0d exp 72", hs_n); else pass_cnt++;
      total_cnt++; if (fs_n != 0) $display("FAIL drain_fs: got %0d exp 0", fs_n); else pass_cnt++;
      total_cnt++; if (hc !== 10'd0 || vc !== 10'd0 || de !== 1'b0) $display("FAIL drain_idle_pos: hc/vc/de got %0d/%0d/%b exp 0/0/0", hc, vc, de); else pass_cnt++;
      total_cnt++; if (hsync !== 1'b1 || vsync !== 1'b1) $display("FAIL drain_idle_sync: got %b%b exp 11", hsync, vsync); else pass_cnt++;
      for (int i = 0; i < 20; i++) begin
         if (pix_tick === 1'b1) pt_n++;
         step(1);
      end
      total_cnt++; if (pt_n != 0 || hc !== 10'd0 || busy !== 1'b0) $display("FAIL idle_hold: ticks/hc/busy got %0d/%0d/%b exp 0/0/0", pt_n, hc, busy); else pass_cnt++;
   endtask

   task automatic test_glitch;
      int fs_n = 0, idle_n = 0;
      en = 1'b1;
      wait_pos(5, 1);
      en = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (i == 10) en = 1'b1;
         step(1);
         if (frame_start === 1'b1) fs_n++;
         if (busy !== 1'b1) idle_n++;
      end
      total_cnt++; if (hc !== 10'd0 || vc !== 10'd2) $display("FAIL glitch_pos: got %0d,%0d exp 0,2", hc, vc); else pass_cnt++;
      total_cnt++; if (fs_n != 0) $display("FAIL glitch_fs: got %0d exp 0", fs_n); else pass_cnt++;
      total_cnt++; if (idle_n != 0) $display("FAIL glitch_busy: busy low %0d clk exp 0", idle_n); else pass_cnt++;
   endtask

   task automatic test_en_at_end;
      wait_pos(3, 6);
      en = 1'b0;
      wait_pos(14, 7);
      step(3);
      total_cnt++; if (pix_tick !== 1'b1 || busy !== 1'b1) $display("FAIL end_tick: tick/busy got %b%b exp 11", pix_tick, busy); else pass_cnt++;
      en = 1'b1;
      step(1);
      total_cnt++; if (hc !== 10'd0 || vc !== 10'd0) $display("FAIL end_wrap_pos: got %0d,%0d exp 0,0", hc, vc); else pass_cnt++;
      total_cnt++; if (busy !== 1'b1 || frame_start !== 1'b1 || de !== 1'b1) $display("FAIL end_keep_run: busy/fs/de got %b%b%b exp 111", busy, frame_start, de); else pass_cnt++;
      step(4);
      total_cnt++; if (hc !== 10'd1 || busy !== 1'b1) $display("FAIL end_continue: hc/busy got %0d/%b exp 1/1", hc, busy); else pass_cnt++;
   endtask

   task automatic test_reset_mid;
      int pt_n = 0;
      bit found = 0;
      for (int i = 0; i < 2000 && !found; i++) begin
         if (hsync === 1'b0 && vc == 10'd3) found = 1;
         else step(1);
      end
      total_cnt++; if (!found) $display("FAIL rmid_wait: hsync low at vc=3 not seen"); else pass_cnt++;
      clr_n = 1'b0;
      step(1);
      total_cnt++; if (hsync !== 1'b1 || vsync !== 1'b1) $display("FAIL rmid_sync: got %b%b exp 11", hsync, vsync); else pass_cnt++;
      total_cnt++; if (hc !== 10'd0 || vc !== 10'd0) $display("FAIL rmid_pos: got %0d,%0d exp 0,0", hc, vc); else pass_cnt++;
      total_cnt++; if (de !== 1'b0 || busy !== 1'b0 || pix_tick !== 1'b0) $display("FAIL rmid_ctrl: de/busy/tick got %b%b%b exp 000", de, busy, pix_tick); else pass_cnt++;
      en    = 1'b0;
      clr_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step(1);
         if (pix_tick === 1'b1) pt_n++;
      end
      total_cnt++; if (pt_n != 0 || hc !== 10'd0 || busy !== 1'b0) $display("FAIL rmid_idle: ticks/hc/busy got %0d/%0d/%b exp 0/0/0", pt_n, hc, busy); else pass_cnt++;
   endtask

   initial begin
      test_reset;
      test_start;
      test_frame;
      test_drain;
      test_glitch;
      test_en_at_end;
      test_reset_mid;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/vga_sync_ctrl.md
# vga_sync_ctrl

Single-clock VGA timing controller that sequences pixel generation from the 100 MHz master clock. An internal pixel-enable divider replaces the ripple-clocked 25 MHz pixel clock. The controller runs horizontal and vertical counters from that enable and produces sync, display-enable and frame/line markers. It sits between the board clock and the pixel/colour logic; downstream logic stays on `clk` and qualifies on `pix_tick`.

## Interface
- `DIV`, 4: `clk` cycles per pixel. Must be ≥ 2.
- `H_VIS` / `H_FP` / `H_SYNC` / `H_BP`, 640 / 16 / 96 / 48: horizontal phase lengths in pixels.
- `V_VIS` / `V_FP` / `V_SYNC` / `V_BP`, 480 / 10 / 2 / 33: vertical phase lengths in lines.
- `clk`, in, 1: master clock, 100 MHz.
- `clr_n`, in, 1: reset. Synchronous, active-low.
- `en`, in, 1: run request. Level-sensitive.
- `pix_tick`, out, 1: one-`clk` pixel enable, asserted once every `DIV` cycles while running.
- `hsync`, out, 1: horizontal sync, active-low.
- `vsync`, out, 1: vertical sync, active-low.
- `de`, out, 1: display enable. High when the pixel is in the visible area.
- `hc`, out, 10: current pixel column.
- `vc`, out, 10: current line.
- `line_start`, out, 1: one-`clk` pulse when `hc` becomes 0.
- `frame_start`, out, 1: one-`clk` pulse when (`hc`,`vc`) becomes (0,0).
- `busy`, out, 1: high in RUN and DRAIN.

## Operation
- Control FSM states: IDLE, RUN, DRAIN.
  - IDLE → RUN when `en`=1.
  - RUN → DRAIN when `en`=0.
  - DRAIN → RUN when `en`=1. There is no interruption of counting or sync.
  - DRAIN → IDLE on the tick that completes the last pixel of the frame (`hc`=H_TOT-1, `vc`=V_TOT-1).
- Totals: H_TOT = sum of the H_* parameters (800). V_TOT = sum of the V_* parameters (525).
- Divider:
  - `cnt` is held at 0 in IDLE.
  - In RUN and DRAIN, `cnt` increments modulo `DIV`.
  - `pix_tick` is high on the cycle where `cnt`=DIV-1.
- Counters advance only on `clk` edges where `pix_tick`=1:
  - `hc` wraps H_TOT-1 → 0.
  - `vc` increments on the `hc` wrap and wraps V_TOT-1 → 0.
- Derived outputs, each a function of the current (`hc`,`vc`) and registered so they are cycle-aligned with the counters:
  - `de` = RUN or DRAIN, and `hc` < H_VIS, and `vc` < V_VIS.
  - `hsync` = 0 when H_VIS+H_FP ≤ `hc` < H_VIS+H_FP+H_SYNC (656..751).
  - `vsync` = 0 when V_VIS+V_FP ≤ `vc` < V_VIS+V_FP+V_SYNC (490..491).
- Markers:
  - `frame_start` and `line_start` pulse on the first cycle of RUN entered from IDLE.
  - They also pulse on every cycle where the counters wrap into 0.
- Widths: `hc` and `vc` are 10 bits. Parameter combinations with H_TOT > 1024 or V_TOT > 1024 are illegal; elaboration asserts.

## Timing
- Reset values: state IDLE, `cnt`=0, `hc`=0, `vc`=0, `hsync`=1, `vsync`=1, `de`=0, `pix_tick`=0, `line_start`=0, `frame_start`=0, `busy`=0.
- `clr_n`=0 at any point, including mid-frame or mid-sync, forces all reset values on the next edge.
- Start latency from IDLE with `en` sampled high at edge N:
  - `busy`=1, `de`=1, `frame_start`=1 and `line_start`=1 after edge N+1.
  - The first `pix_tick` occurs DIV cycles after RUN entry.
  - `hc` becomes 1 on the edge closing that tick cycle.
- In IDLE the outputs hold `hc`=`vc`=0, `hsync`=`vsync`=1 and `de`=0. `pix_tick` never asserts in IDLE.
- `en` glitches shorter than a frame during RUN cause no visible effect: the path is RUN→DRAIN→RUN.
- `en` high on the exact tick where DRAIN completes: the block stays running. RUN takes priority, and `hc` and `vc` wrap normally.
- Frame period: DIV × 800 × 525 = 1,680,000 `clk` cycles.

## Structure
- Package `vga_timing_pkg` holds:
  - default 640×480@60 phase constants;
  - the H_TOT/V_TOT helper functions;
  - the control-state encoding (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2).
- Sub-module `pix_tick_gen` (ports `clk`, `clr_n`, `run`, `pix_tick`; parameter `DIV`) contains the divider. All remaining logic lives in `vga_sync_ctrl`.

## Test plan
- Reset with `en`=1 held, then release `clr_n`: `busy` rises 1 cycle after release, `frame_start` pulses once, and the first `pix_tick` comes 4 cycles after RUN entry.
- Run one line: `hsync` is low for exactly 96 ticks (384 `clk`) starting at `hc`=656, `de` is low from `hc`=640, and `line_start` repeats every 3200 `clk`.
- Run a full frame: `vsync` is low for `vc`=490..491 (1600 ticks), and the `frame_start` spacing is 1,680,000 `clk`.
- Drop `en` at `hc`=100, `vc`=200: sync continues, then IDLE is entered after (`hc`,`vc`)=(799,524), with `hc`=`vc`=0, `busy`=0 and no further `pix_tick`.
- Pulse `en` low for 10 cycles mid-frame: the counter sequence is unbroken and no extra `frame_start` occurs.
- Assert `clr_n`=0 while `hsync`=0 at `vc`=300: on the next edge `hsync`=1, `hc`=`vc`=0 and `de`=0.
